// File: rtl/wb2stream.sv
// Wishbone slave to byte-stream bridge: each bus access becomes a command frame,
// reads wait for a 4-byte response (or a timeout) before acknowledging.
module wb2stream #(
  parameter int unsigned TIMEOUT = 65535,
  parameter int unsigned TW      = $clog2(TIMEOUT + 1)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] wb_addr,
  input  logic [31:0] wb_wdata,
  output logic [31:0] wb_rdata,
  input  logic        wb_we,
  input  logic        wb_cyc,
  output logic        wb_ack,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        timeout_flag,
  input  logic        timeout_clr
);

  typedef enum logic [1:0] {IDLE, TX, RX, ACK} state_t;

  state_t        state, state_nxt;
  logic [15:0]   addr_q;
  logic [31:0]   wdata_q;
  logic          we_q;
  logic [2:0]    idx;
  logic [1:0]    cnt;
  logic [31:0]   sr;
  logic [TW-1:0] timer;
  logic [31:0]   result;
  logic          ack_q;
  logic          txv_q;
  logic          flag_q;
  logic [7:0]    frame_byte;
  logic          last_byte;
  logic          rx_done;
  logic          rx_expire;

  always_comb begin
    frame_byte = '0;
    case (idx)
      3'd0:    frame_byte = we_q ? 8'h01 : 8'h02;
      3'd1:    frame_byte = addr_q[15:8];
      3'd2:    frame_byte = addr_q[7:0];
      3'd3:    frame_byte = wdata_q[31:24];
      3'd4:    frame_byte = wdata_q[23:16];
      3'd5:    frame_byte = wdata_q[15:8];
      3'd6:    frame_byte = wdata_q[7:0];
      default: frame_byte = '0;
    endcase
  end

  assign last_byte = we_q ? (idx == 3'd6) : (idx == 3'd2);
  // A 4th response byte arriving on the final timer cycle takes precedence.
  assign rx_done   = rx_valid && (cnt == 2'd3);
  assign rx_expire = (timer == TW'(TIMEOUT - 1)) && !rx_done;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (wb_cyc) state_nxt = TX;
      TX:   if (tx_ready && last_byte) state_nxt = we_q ? ACK : RX;
      RX:   if (rx_done || rx_expire) state_nxt = ACK;
      ACK:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      idx     <= '0;
      cnt     <= '0;
      sr      <= '0;
      timer   <= '0;
      result  <= '0;
      ack_q   <= 1'b0;
      txv_q   <= 1'b0;
      flag_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      ack_q <= (state_nxt == ACK);
      txv_q <= (state_nxt == TX);
      if (timeout_clr) flag_q <= 1'b0;
      if (state == RX && rx_expire) flag_q <= 1'b1;
      case (state)
        IDLE: if (wb_cyc) begin
          addr_q  <= wb_addr;
          wdata_q <= wb_wdata;
          we_q    <= wb_we;
          idx     <= '0;
        end
        TX: if (tx_ready) begin
          idx <= idx + 3'd1;
          if (last_byte) begin
            sr     <= '0;
            timer  <= '0;
            cnt    <= '0;
            result <= '0;
          end
        end
        RX: begin
          timer <= timer + TW'(1);
          if (rx_valid) begin
            sr  <= {sr[23:0], rx_data};
            cnt <= cnt + 2'd1;
          end
          if (rx_done)        result <= {sr[23:0], rx_data};
          else if (rx_expire) result <= '1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    wb_ack       = ack_q;
    wb_rdata     = ack_q ? result : '0;
    tx_valid     = txv_q;
    tx_data      = txv_q ? frame_byte : '0;
    timeout_flag = flag_q;
  end

endmodule
